counter_table: RTL and testbench

Parametrised table of saturating counters with two combinational read ports, a read-modify-write update port and a raw write port. It generalises the plain two-read/one-write array to width-agnostic saturating arithmetic, and to a hardware initialisation sweep driven by reset. It sits in the fetch stage as the branch-prediction pattern table: reads come from fetch, and updates and writes come from the resolving stage.

---
 rtl/counter_table.sv | 112 +++++++++++
 tb/tb_counter_table.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/counter_table.sv
// counter_table: table of saturating counters with two combinational read
// ports, a read-modify-write update port and a raw write port. A reset-driven
// sweep loads init_value into every entry before the table reports ready.
//
// Optional feature: define COUNTER_TABLE_BYPASS_EN to forward the value being
// committed this cycle to any read port addressing the same entry.
//
// state | meaning
// INIT  | sweeping init_value into entry ptr_q, reads return init_value
// READY | table live, reads/updates/writes honoured

module counter_table #(
    parameter int width      = 2,
    parameter int index_bits = 5,
    parameter int init_value = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [index_bits-1:0] read1_index,
    input  logic [index_bits-1:0] read2_index,
    output logic [width-1:0]      data1_out,
    output logic [width-1:0]      data2_out,
    input  logic                  update,
    input  logic [index_bits-1:0] update_index,
    input  logic                  taken,
    input  logic                  write,
    input  logic [index_bits-1:0] write_index,
    input  logic [width-1:0]      datain,
    output logic                  ready
);

    localparam int              depth    = 2 ** index_bits;
    localparam logic [width-1:0] init_val = width'(init_value);
    localparam logic [width-1:0] cnt_max  = '1;
    localparam logic [width-1:0] cnt_one  = width'(1);

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } state_t;

    state_t                  state_q;
    state_t                  state_d;
    logic [index_bits-1:0]   ptr_q;
    logic [width-1:0]        mem [depth];
    logic [width-1:0]        upd_old;
    logic [width-1:0]        upd_val;
    logic                    update_en;

    // State register and sweep pointer; reset restarts the sweep from entry 0
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= INIT;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == INIT) begin
                ptr_q <= ptr_q + 1'b1;
            end
        end
    end

    // Next state: leave INIT on the edge that writes the last entry
    always_comb begin
        state_d = state_q;
        if (state_q == INIT && ptr_q == '1) begin
            state_d = READY;
        end
    end

    // Saturating next value for the update port; a same-index write wins
    always_comb begin
        upd_old   = mem[update_index];
        upd_val   = upd_old;
        if (taken) begin
            if (upd_old != cnt_max) upd_val = upd_old + cnt_one;
        end else begin
            if (upd_old != '0) upd_val = upd_old - cnt_one;
        end
        update_en = update && !(write && (write_index == update_index));
    end

    // Table storage: sweep writes in INIT, update/write commits in READY
    always_ff @(posedge clk) begin
        if (reset_n) begin
            if (state_q == INIT) begin
                mem[ptr_q] <= init_val;
            end else begin
                if (update_en) mem[update_index] <= upd_val;
                if (write)     mem[write_index]  <= datain;
            end
        end
    end

    // Outputs: ready decodes the state flop directly, reads are combinational
    always_comb begin
        ready     = (state_q == READY);
        data1_out = init_val;
        data2_out = init_val;
        if (state_q == READY) begin
            data1_out = mem[read1_index];
            data2_out = mem[read2_index];
`ifdef COUNTER_TABLE_BYPASS_EN
            if (update_en && update_index == read1_index) data1_out = upd_val;
            if (update_en && update_index == read2_index) data2_out = upd_val;
            if (write && write_index == read1_index)      data1_out = datain;
            if (write && write_index == read2_index)      data2_out = datain;
`endif
        end
    end

endmodule

// File: tb/tb_counter_table.sv
// Directed testbench for counter_table with default parameters
// (width=2, index_bits=5, init_value=1).

module tb_counter_table;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [4:0] read1_index;
    logic [4:0] read2_index;
    logic [1:0] data1_out;
    logic [1:0] data2_out;
    logic       update;
    logic [4:0] update_index;
    logic       taken;
    logic       write;
    logic [4:0] write_index;
    logic [1:0] datain;
    logic       ready;

    int n_tests = 0;
    int n_fail  = 0;

`ifdef COUNTER_TABLE_BYPASS_EN
    localparam bit byp = 1'b1;
`else
    localparam bit byp = 1'b0;
`endif

    counter_table #(
        .width     (2),
        .index_bits(5),
        .init_value(1)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .read1_index (read1_index),
        .read2_index (read2_index),
        .data1_out   (data1_out),
        .data2_out   (data2_out),
        .update      (update),
        .update_index(update_index),
        .taken       (taken),
        .write       (write),
        .write_index (write_index),
        .datain      (datain),
        .ready       (ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // advance one rising edge, then sample 1ns later
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic check_all(input string tag, input int exp);
        for (int i = 0; i < 32; i++) begin
            read1_index = 5'(i);
            read2_index = 5'(31 - i);
            settle();
            check({tag, "_r1"}, int'(data1_out), exp);
            check({tag, "_r2"}, int'(data2_out), exp);
        end
    endtask

    task automatic sweep_32(input string tag);
        for (int k = 1; k <= 32; k++) begin
            read1_index = 5'(k - 1);
            read2_index = 5'(31 - (k - 1));
            settle();
            check({tag, "_ready_low"}, int'(ready), 0);
            check({tag, "_init_r1"}, int'(data1_out), 1);
            check({tag, "_init_r2"}, int'(data2_out), 1);
            step();
        end
        check({tag, "_ready_high"}, int'(ready), 1);
    endtask

    int inc_exp [4] = '{2, 3, 3, 3};
    int dec_exp [4] = '{2, 1, 0, 0};
    int inc_byp [4] = '{3, 3, 3, 3};
    int dec_byp [4] = '{1, 0, 0, 0};

    initial begin
        reset_n      = 1'b0;
        read1_index  = '0;
        read2_index  = '0;
        update       = 1'b0;
        update_index = '0;
        taken        = 1'b0;
        write        = 1'b0;
        write_index  = '0;
        datain       = '0;

        // reset held for two edges, then the sweep with a write pulse at edge 2
        step();
        step();
        check("rst_ready", int'(ready), 0);
        check("rst_r1", int'(data1_out), 1);
        reset_n = 1'b1;
        for (int k = 1; k <= 32; k++) begin
            write       = (k == 2);
            write_index = 5'd31;
            datain      = 2'd3;
            read1_index = 5'(k - 1);
            read2_index = 5'd31;
            settle();
            check("init_ready_low", int'(ready), 0);
            check("init_r1", int'(data1_out), 1);
            check("init_r2", int'(data2_out), 1);
            step();
        end
        write = 1'b0;
        check("init_ready_high", int'(ready), 1);
        check_all("init_all", 1);
        read1_index = 5'd31;
        settle();
        check("init_write_ignored", int'(data1_out), 1);

        // saturation on index 5
        read1_index  = 5'd5;
        update       = 1'b1;
        update_index = 5'd5;
        taken        = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            check("sat_inc", int'(data1_out), byp ? inc_byp[k] : inc_exp[k]);
        end
        taken = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            check("sat_dec", int'(data1_out), byp ? dec_byp[k] : dec_exp[k]);
        end
        update = 1'b0;
        settle();
        check("sat_floor", int'(data1_out), 0);

        // same-index collision: write wins
        write        = 1'b1;
        write_index  = 5'd7;
        datain       = 2'd0;
        update       = 1'b1;
        update_index = 5'd7;
        taken        = 1'b1;
        step();
        write  = 1'b0;
        update = 1'b0;
        read1_index = 5'd7;
        settle();
        check("coll_same_idx7", int'(data1_out), 0);

        // different indices: both commit
        write        = 1'b1;
        write_index  = 5'd7;
        datain       = 2'd0;
        update       = 1'b1;
        update_index = 5'd8;
        taken        = 1'b1;
        step();
        write  = 1'b0;
        update = 1'b0;
        read1_index = 5'd7;
        read2_index = 5'd8;
        settle();
        check("coll_diff_idx7", int'(data1_out), 0);
        check("coll_diff_idx8", int'(data2_out), 2);

        // read of an entry being updated / written in the same cycle
        read1_index  = 5'd3;
        update       = 1'b1;
        update_index = 5'd3;
        taken        = 1'b1;
        read2_index  = 5'd9;
        write        = 1'b1;
        write_index  = 5'd9;
        datain       = 2'd3;
        settle();
        check("byp_upd_same_cycle", int'(data1_out), byp ? 2 : 1);
        check("byp_wr_same_cycle", int'(data2_out), byp ? 3 : 1);
        step();
        update = 1'b0;
        write  = 1'b0;
        settle();
        check("byp_upd_next", int'(data1_out), 2);
        check("byp_wr_next", int'(data2_out), 3);

        // load 3 into several entries, reset in READY, abort the sweep at edge 10
        write  = 1'b1;
        datain = 2'd3;
        for (int i = 0; i < 32; i += 5) begin
            write_index = 5'(i);
            step();
        end
        write_index = 5'd31;
        step();
        write = 1'b0;
        read1_index = 5'd31;
        settle();
        check("pre_reset_idx31", int'(data1_out), 3);
        reset_n = 1'b0;
        step();
        check("rst_ready_drop", int'(ready), 0);
        reset_n = 1'b1;
        for (int k = 1; k <= 9; k++) step();
        reset_n = 1'b0;
        step();
        check("mid_rst_ready", int'(ready), 0);
        reset_n = 1'b1;
        sweep_32("mid_rst");
        check_all("mid_rst_all", 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
